// File: rtl/w5300_bus_scheduler.sv
// Top-level sequencer and single-bus arbiter for the W5300 driver: runs common/ID/socket bring-up,
// then shares the w5300_interface bus between the IRQ handler and round-robin data channels.
module w5300_bus_scheduler #(
  parameter int          SOCKETS    = 2,
  parameter int          CHANNELS   = 4,
  parameter int          CLK_FREQ   = 100,
  parameter int          TIMEOUT_US = 60,
  parameter logic [9:0]  ID_ADDR    = 10'h3FE,
  parameter logic [15:0] ID_VALUE   = 16'h5300,
  parameter int          HS_RETRIES = 4,
  parameter int          MAX_REINIT = 3,
  localparam int         SW = (SOCKETS > 1) ? $clog2(SOCKETS) : 1,
  localparam int         CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   int_n,
  input  logic                   bus_ready,
  input  logic [15:0]            bus_rd_data,
  output logic [10:0]            bus_addr,
  output logic [15:0]            bus_wr_data,
  output logic                   com_en,
  input  logic                   com_done,
  input  logic [10:0]            com_addr,
  input  logic [15:0]            com_wr_data,
  output logic                   sock_en,
  output logic [SW-1:0]          sock_sel,
  input  logic                   sock_done,
  input  logic [10:0]            sock_addr,
  input  logic [15:0]            sock_wr_data,
  output logic                   irq_en,
  input  logic                   irq_done,
  input  logic [10:0]            irq_addr,
  input  logic [15:0]            irq_wr_data,
  input  logic [CHANNELS-1:0]    ch_req,
  output logic [CHANNELS-1:0]    ch_gnt,
  input  logic                   ch_done,
  input  logic [11*CHANNELS-1:0] ch_addr,
  input  logic [16*CHANNELS-1:0] ch_wr_data,
  output logic [3:0]             state,
  output logic                   err,
  output logic [2:0]             err_code
);

  typedef enum logic [3:0] {
    ST_INIT      = 4'd0,
    ST_COMMON    = 4'd1,
    ST_HANDSHAKE = 4'd2,
    ST_SOCKCFG   = 4'd3,
    ST_IDLE      = 4'd4,
    ST_IRQ       = 4'd5,
    ST_CHAN      = 4'd6,
    ST_ERROR     = 4'd7,
    ST_FATAL     = 4'd8
  } state_t;

  localparam logic [31:0]         TO_CYC  = 32'(TIMEOUT_US * CLK_FREQ);
  localparam logic [CHANNELS-1:0] CH_ONE  = CHANNELS'(1'b1);
  localparam logic [10:0]         BUS_IDLE = 11'h400;

  state_t              state_r, state_nxt_s;
  logic [31:0]         wd_cnt_r;
  logic [7:0]          hs_cnt_r;
  logic [7:0]          reinit_cnt_r;
  logic [1:0]          int_sync_r;
  logic                irq_pend_s;
  logic                last_irq_r;
  logic [CW-1:0]       last_ch_r;
  logic [CW-1:0]       rr_pick_s;
  logic                rr_found_s;
  logic                wd_expired_s;
  logic [2:0]          err_code_r, err_code_nxt_s;
  logic                err_r;
  logic                com_en_r, sock_en_r, irq_en_r;
  logic [SW-1:0]       sock_sel_r;
  logic [CHANNELS-1:0] ch_gnt_r;

  assign irq_pend_s   = ~int_sync_r[1];
  assign wd_expired_s = (wd_cnt_r == TO_CYC - 32'd1);

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    rr_found_s = 1'b0;
    rr_pick_s  = last_ch_r;
    for (int k = 1; k <= CHANNELS; k++) begin
      rr_pick_s  = (!rr_found_s && ch_req[(int'(last_ch_r) + k) % CHANNELS]) ?
                   CW'((int'(last_ch_r) + k) % CHANNELS) : rr_pick_s;
      rr_found_s = rr_found_s | ch_req[(int'(last_ch_r) + k) % CHANNELS];
    end
  end

  // Next-state and error-code decode; done is checked before the watchdog so it wins a tie.
  always_comb begin
    state_nxt_s    = state_r;
    err_code_nxt_s = err_code_r;
    case (state_r)
      ST_INIT: begin
        if (bus_ready) state_nxt_s = ST_COMMON;
        else           state_nxt_s = ST_INIT;
      end
      ST_COMMON: begin
        if (com_done)          state_nxt_s = ST_HANDSHAKE;
        else if (wd_expired_s) begin state_nxt_s = ST_ERROR; err_code_nxt_s = 3'd1; end
        else                   state_nxt_s = ST_COMMON;
      end
      ST_HANDSHAKE: begin
        if (bus_ready && bus_rd_data == ID_VALUE)           state_nxt_s = ST_SOCKCFG;
        else if (bus_ready && hs_cnt_r == 8'(HS_RETRIES - 1)) begin
          state_nxt_s = ST_ERROR; err_code_nxt_s = 3'd2;
        end
        else                                                state_nxt_s = ST_HANDSHAKE;
      end
      ST_SOCKCFG: begin
        if (sock_done && sock_sel_r == SW'(SOCKETS - 1)) state_nxt_s = ST_IDLE;
        else if (sock_done)                              state_nxt_s = ST_SOCKCFG;
        else if (wd_expired_s) begin state_nxt_s = ST_ERROR; err_code_nxt_s = 3'd3; end
        else                                             state_nxt_s = ST_SOCKCFG;
      end
      ST_IDLE: begin
        // A pending IRQ yields once to waiting channels after it was just serviced.
        if (irq_pend_s && !(last_irq_r && rr_found_s)) state_nxt_s = ST_IRQ;
        else if (rr_found_s)                          state_nxt_s = ST_CHAN;
        else                                          state_nxt_s = ST_IDLE;
      end
      ST_IRQ: begin
        if (irq_done)          state_nxt_s = ST_IDLE;
        else if (wd_expired_s) begin state_nxt_s = ST_ERROR; err_code_nxt_s = 3'd4; end
        else                   state_nxt_s = ST_IRQ;
      end
      ST_CHAN: begin
        if (ch_done)           state_nxt_s = ST_IDLE;
        else if (wd_expired_s) begin state_nxt_s = ST_ERROR; err_code_nxt_s = 3'd5; end
        else                   state_nxt_s = ST_CHAN;
      end
      ST_ERROR: begin
        if (wd_cnt_r == 32'd15 && reinit_cnt_r == 8'(MAX_REINIT)) begin
          state_nxt_s = ST_FATAL; err_code_nxt_s = 3'd7;
        end
        else if (wd_cnt_r == 32'd15) state_nxt_s = ST_INIT;
        else                         state_nxt_s = ST_ERROR;
      end
      ST_FATAL: state_nxt_s = ST_FATAL;
      default:  state_nxt_s = ST_INIT;
    endcase
  end

  // State, counters, synchronizer and registered client controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_INIT;
      wd_cnt_r     <= 32'd0;
      hs_cnt_r     <= 8'd0;
      reinit_cnt_r <= 8'd0;
      int_sync_r   <= 2'b11;
      last_irq_r   <= 1'b0;
      last_ch_r    <= CW'(CHANNELS - 1);
      err_r        <= 1'b0;
      err_code_r   <= 3'd0;
      com_en_r     <= 1'b0;
      sock_en_r    <= 1'b0;
      irq_en_r     <= 1'b0;
      sock_sel_r   <= '0;
      ch_gnt_r     <= '0;
    end else begin
      state_r    <= state_nxt_s;
      int_sync_r <= {int_sync_r[0], int_n};
      wd_cnt_r   <= (state_nxt_s != state_r) ? 32'd0 :
                    (wd_cnt_r == 32'hFFFF_FFFF) ? wd_cnt_r : wd_cnt_r + 32'd1;
      hs_cnt_r   <= (state_r != ST_HANDSHAKE) ? 8'd0 :
                    (bus_ready ? hs_cnt_r + 8'd1 : hs_cnt_r);
      reinit_cnt_r <= (state_r == ST_ERROR && state_nxt_s == ST_INIT) ?
                      reinit_cnt_r + 8'd1 : reinit_cnt_r;
      err_r      <= err_r | (state_nxt_s == ST_ERROR) | (state_nxt_s == ST_FATAL);
      err_code_r <= err_code_nxt_s;
      com_en_r   <= (state_nxt_s == ST_COMMON);
      sock_en_r  <= (state_nxt_s == ST_SOCKCFG);
      irq_en_r   <= (state_nxt_s == ST_IRQ);
      sock_sel_r <= (state_nxt_s != ST_SOCKCFG) ? '0 :
                    ((state_r == ST_SOCKCFG && sock_done) ? sock_sel_r + SW'(1) : sock_sel_r);
      if (state_r == ST_IDLE && state_nxt_s == ST_IRQ) begin
        last_irq_r <= 1'b1;
      end else if (state_r == ST_IDLE && state_nxt_s == ST_CHAN) begin
        last_irq_r <= 1'b0;
        last_ch_r  <= rr_pick_s;
      end else begin
        last_irq_r <= last_irq_r;
        last_ch_r  <= last_ch_r;
      end
      ch_gnt_r <= (state_nxt_s != ST_CHAN) ? '0 :
                  ((state_r == ST_IDLE) ? (CH_ONE << rr_pick_s) : ch_gnt_r);
    end
  end

  // Bus mux: the client owning the current state drives the interface.
  always_comb begin
    bus_addr    = BUS_IDLE;
    bus_wr_data = 16'h0000;
    case (state_r)
      ST_COMMON:    begin bus_addr = com_addr;           bus_wr_data = com_wr_data;  end
      ST_HANDSHAKE: begin bus_addr = {1'b1, ID_ADDR};    bus_wr_data = 16'h0000;     end
      ST_SOCKCFG:   begin bus_addr = sock_addr;          bus_wr_data = sock_wr_data; end
      ST_IRQ:       begin bus_addr = irq_addr;           bus_wr_data = irq_wr_data;  end
      ST_CHAN: begin
        bus_addr    = ch_addr[11*last_ch_r +: 11];
        bus_wr_data = ch_wr_data[16*last_ch_r +: 16];
      end
      default:      begin bus_addr = BUS_IDLE;           bus_wr_data = 16'h0000;     end
    endcase
  end

  assign state    = state_r;
  assign err      = err_r;
  assign err_code = err_code_r;
  assign com_en   = com_en_r;
  assign sock_en  = sock_en_r;
  assign sock_sel = sock_sel_r;
  assign irq_en   = irq_en_r;
  assign ch_gnt   = ch_gnt_r;

endmodule
